// File: rtl/minimig_audio_control.sv
// Minimig audio control registers with ramped volume channels and overflow monitor.
// Optional mute register enabled by MINIMIG_AUDCTRL_MUTE_EN.
module minimig_audio_control #(
  parameter int          NUM_VOL    = 5,
  parameter int          VOL_WIDTH  = 8,
  parameter logic [7:0]  VOL_RESET  = 8'h80,
  parameter logic [15:0] RAMP_RESET = 16'd0,
  parameter logic [15:0] CAPS       = 16'h0005
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [15:0]                  data_in,
  output logic [15:0]                  data_out,
  input  logic [15:1]                  addr,
  input  logic                         rd,
  input  logic                         hwr,
  input  logic                         lwr,
  input  logic                         sel,
  input  logic                         audio_overflow,
  output logic [NUM_VOL*VOL_WIDTH-1:0] vol_out,
  output logic                         sermidi,
  output logic                         drivesound_fdd,
  output logic                         drivesound_hdd
);

  localparam logic [VOL_WIDTH-1:0] VRST = VOL_RESET[VOL_WIDTH-1:0];
  localparam logic [2:0] NV_M1 = 3'(NUM_VOL - 1);
  localparam logic [7:0] VEND = 8'(8 + NUM_VOL);

  logic [7:0] a;
  logic [7:0] vidx;
  logic       wr;
  logic       vsel;
  logic       div_wr;
  logic       ovf_clr;
  logic       tick;
  logic       busy;
  logic       mute;
  logic       unused_ok;

  assign a         = addr[8:1];
  assign wr        = sel & lwr;
  assign vidx      = a - 8'h08;
  assign vsel      = (a >= 8'h08) && (a < VEND);
  assign div_wr    = wr && (a == 8'h05);
  assign ovf_clr   = wr && (a == 8'h06);
  assign unused_ok = ^{hwr, addr[15:9]};

  logic                 sermidi_q, fdd_q, hdd_q;
  logic [15:0]          div_q, cnt_q, cnt_d;
  logic                 ovf_flag_q, ovf_flag_d;
  logic [7:0]           ovf_cnt_q, ovf_cnt_d;
  logic [15:0]          data_out_q, rdata;
  logic [VOL_WIDTH-1:0] tgt_q [NUM_VOL];
  logic [VOL_WIDTH-1:0] tgt_d [NUM_VOL];
  logic [VOL_WIDTH-1:0] cur_q [NUM_VOL];
  logic [VOL_WIDTH-1:0] cur_d [NUM_VOL];
  logic [VOL_WIDTH-1:0] eff   [NUM_VOL];

`ifdef MINIMIG_AUDCTRL_MUTE_EN
  localparam logic MUTE_PRESENT = 1'b1;
  logic mute_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mute_q <= 1'b0;
    end else if (wr && (a == 8'h03)) begin
      mute_q <= data_in[0];
    end
  end
  assign mute = mute_q;
`else
  localparam logic MUTE_PRESENT = 1'b0;
  assign mute = 1'b0;
`endif

  // A divisor write restarts the tick period without emitting a tick.
  assign tick  = (cnt_q == 16'd0) && !div_wr;
  assign cnt_d = div_wr ? data_in :
                 (cnt_q == 16'd0) ? div_q : cnt_q - 16'd1;

  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < NUM_VOL; i++) begin
      eff[i]   = mute ? '0 : tgt_q[i];
      tgt_d[i] = tgt_q[i];
      cur_d[i] = cur_q[i];
      busy     = busy | (cur_q[i] != eff[i]);
      if (wr && vsel && (vidx == 8'(i))) begin
        tgt_d[i] = data_in[VOL_WIDTH-1:0];
      end
      if (div_q == 16'd0) begin
        cur_d[i] = eff[i];
      end else if (tick) begin
        if (cur_q[i] < eff[i]) begin
          cur_d[i] = cur_q[i] + 1'b1;
        end else if (cur_q[i] > eff[i]) begin
          cur_d[i] = cur_q[i] - 1'b1;
        end
      end
    end
  end

  // Clear takes priority, so a coincident pulse still counts once.
  always_comb begin
    ovf_flag_d = ovf_clr ? 1'b0 : ovf_flag_q;
    ovf_cnt_d  = ovf_clr ? 8'd0 : ovf_cnt_q;
    if (audio_overflow) begin
      ovf_flag_d = 1'b1;
      if (ovf_cnt_d != 8'hFF) begin
        ovf_cnt_d = ovf_cnt_d + 8'd1;
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (a)
      8'h00: rdata = {15'd0, sermidi_q};
      8'h01: rdata = {14'd0, hdd_q, fdd_q};
      8'h03: rdata = {15'd0, mute};
      8'h04: rdata = {15'd0, busy};
      8'h05: rdata = div_q;
      8'h06: rdata = {ovf_cnt_q, 7'd0, ovf_flag_q};
      8'h07: rdata = {CAPS[15:12], NV_M1, MUTE_PRESENT, CAPS[7:0]};
      default: begin
        for (int i = 0; i < NUM_VOL; i++) begin
          if (vsel && (vidx == 8'(i))) begin
            rdata = {8'(cur_q[i]), 8'(tgt_q[i])};
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sermidi_q  <= 1'b1;
      fdd_q      <= 1'b0;
      hdd_q      <= 1'b0;
      div_q      <= RAMP_RESET;
      cnt_q      <= RAMP_RESET;
      ovf_flag_q <= 1'b0;
      ovf_cnt_q  <= 8'd0;
      data_out_q <= 16'd0;
      for (int i = 0; i < NUM_VOL; i++) begin
        tgt_q[i] <= VRST;
        cur_q[i] <= VRST;
      end
    end else begin
      if (wr && (a == 8'h00)) sermidi_q <= data_in[0];
      if (wr && (a == 8'h01)) begin
        fdd_q <= data_in[0];
        hdd_q <= data_in[1];
      end
      if (div_wr) div_q <= data_in;
      cnt_q      <= cnt_d;
      ovf_flag_q <= ovf_flag_d;
      ovf_cnt_q  <= ovf_cnt_d;
      data_out_q <= (sel && rd) ? rdata : 16'd0;
      for (int i = 0; i < NUM_VOL; i++) begin
        tgt_q[i] <= tgt_d[i];
        cur_q[i] <= cur_d[i];
      end
    end
  end

  always_comb begin
    vol_out = '0;
    for (int i = 0; i < NUM_VOL; i++) begin
      vol_out[i*VOL_WIDTH +: VOL_WIDTH] = cur_q[i];
    end
  end

  assign data_out       = data_out_q;
  assign sermidi        = sermidi_q;
  assign drivesound_fdd = fdd_q;
  assign drivesound_hdd = hdd_q;

endmodule

// File: doc/minimig_audio_control.md
Name: minimig_audio_control

Overview:
- Parametrised successor of the Minimig control-board register block.
- Holds MIDI/drive-sound switches, an overflow monitor and NUM_VOL volume channels on the same 16-bit chip-register bus.
- Adds per-channel volume ramping driven by a programmable tick divider, so gain changes are smooth rather than abrupt.
- Adds a saturating overflow event counter and a busy status; sits between the CPU register decoder and the audio mixer.

Parameters:
- NUM_VOL, 5, number of volume channels (1..8).
- VOL_WIDTH, 8, bits per volume value (1..8).
- VOL_RESET, 8'h80, reset value of every target and current volume (truncated to VOL_WIDTH).
- RAMP_RESET, 16'd0, reset value of the ramp divisor (0 = no ramping).
- CAPS, 16'h0005, capability bits reported at register 0x07.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- data_in  in  16  write data
- data_out  out  16  registered read data
- addr  in  15 ([15:1])  word address; addr[8:1] decoded
- rd  in  1  read strobe
- hwr  in  1  upper-byte write strobe (unused, reserved)
- lwr  in  1  lower-byte write strobe; all writes use lwr
- sel  in  1  block select
- audio_overflow  in  1  one-cycle overflow pulse from the mixer
- vol_out  out  NUM_VOL*VOL_WIDTH  current volumes; channel i at [i*VOL_WIDTH +: VOL_WIDTH]
- sermidi  out  1  serial-to-MIDI routing
- drivesound_fdd  out  1  floppy sound enable
- drivesound_hdd  out  1  hard-disk sound enable

Behaviour:
- Clock and reset: one clock. Reset is asynchronous, active-low.
- Reset values: sermidi=1, drivesound_fdd=0, drivesound_hdd=0, data_out=0. Every tgt[i] and cur[i]=VOL_RESET. div=RAMP_RESET, tick counter=RAMP_RESET. ovf_flag=0, ovf_cnt=0.
- A write is sel&&lwr; it takes effect on that clock edge.
- Register map, by addr[8:1]:
  - 0x00: bit0 sermidi (R/W).
  - 0x01: bits1:0 {hdd,fdd} (R/W).
  - 0x03: mute (see Optional Feature).
  - 0x04: read-only; bit0 busy = OR over all channels of (cur!=effective target).
  - 0x05: 16-bit ramp divisor div (R/W).
  - 0x06: read {ovf_cnt[7:0],7'b0,ovf_flag}; any write clears both.
  - 0x07: read {CAPS[15:12], NUM_VOL-1 (3 bits), mute_present, CAPS[7:0]}.
  - 0x08+i, for i<NUM_VOL: write sets tgt[i]=data_in[VOL_WIDTH-1:0]; read returns {cur[i] zero-extended to 8 bits, tgt[i] zero-extended to 8 bits}.
  - Unmapped addresses and i>=NUM_VOL: writes ignored, read returns 0.
- Read: if sel&&rd, data_out is loaded next edge (1-cycle latency); otherwise data_out<=0.
- Overflow: an audio_overflow pulse sets ovf_flag and increments ovf_cnt, saturating at 255. If a pulse coincides with a clear write, the clear applies first, leaving flag=1 and cnt=1.
- Tick generator:
  - Counter decrements each clock. At 0 it emits a one-cycle tick and reloads div.
  - Writing 0x05 reloads the counter with the new value on the next edge, with no tick that cycle.
- Ramp, per channel:
  - div!=0: on each tick cur moves 1 LSB toward the effective target. No change when equal; never overshoots.
  - div==0: cur<=effective target every clock, giving 1-cycle latency from the write.
- A target written mid-ramp redirects the ramp from the present cur; cur is not reset.
- rst_n low mid-ramp returns all state to reset values immediately.

Optional Feature:
- Macro: MINIMIG_AUDCTRL_MUTE_EN.
- Defined:
  - Register 0x03 bit0 mute (R/W, reset 0); mute_present=1.
  - While mute=1, the effective target of every channel is 0. cur ramps to 0 under the normal ramp rules; tgt registers are preserved and read back unchanged.
  - Clearing mute ramps cur back to tgt.
- Undefined:
  - 0x03 writes ignored, reads 0, mute_present=0.
  - Effective target = tgt.

Test Plan:
- Reset -> vol_out all 8'h80, sermidi=1, drivesounds 0. Read 0x07 with defaults -> 16'h0805 (mute off) or 16'h0905 (mute on).
- div=0; write 0x08=8'h10 -> ch0 cur=8'h10 one clock after the write edge. Read 0x08 -> 16'h1010.
- Write div=3, then ch1 target 8'h84 from 8'h80 -> cur increments every 4 clocks, reaches 8'h84 after 16 clocks. busy=1 during the ramp, 0 after.
- Mid-ramp, retarget ch1 from 8'h84 to 8'h7E while cur=8'h82 -> cur steps down 8'h81,8'h80,8'h7F,8'h7E and never exceeds 8'h82.
- 300 overflow pulses -> read 0x06 = 16'hFF01. Write 0x06 in the same cycle as a pulse -> read = 16'h0101.
- With MINIMIG_AUDCTRL_MUTE_EN and div=0: mute=1 -> all cur=0 next clock, tgt reads unchanged. mute=0 -> cur restored. Without the macro, 0x03 reads 0.
